// File: rtl/mdio_responder.sv
// rtl/mdio_responder.sv - Clause-22 MDIO PHY-side responder with an 8-entry register file
// MDC/MDIO are oversampled on clk_in; frames decode on MDC rise, the pad is driven on MDC fall.
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter int          MIN_PREAMBLE = 32,
  parameter logic [15:0] ID1          = 16'h0022,
  parameter logic [15:0] ID2          = 16'h1561
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic        link_up,
  output logic [15:0] ctrl_reg,
  output logic        wr_strobe,
  output logic [4:0]  wr_addr,
  output logic        frame_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ST2   = 3'd1;
  localparam logic [2:0] S_OP    = 3'd2;
  localparam logic [2:0] S_PHYAD = 3'd3;
  localparam logic [2:0] S_REGAD = 3'd4;
  localparam logic [2:0] S_WTA   = 3'd5;
  localparam logic [2:0] S_WDATA = 3'd6;
  localparam logic [2:0] S_RD    = 3'd7;

  localparam logic [15:0] REG0_RST = 16'h3100;

  logic        mdc_s1_q, mdc_s1_d, mdc_s2_q, mdc_s2_d, mdc_dly_q, mdc_dly_d;
  logic        mdio_s1_q, mdio_s1_d, mdio_s2_q, mdio_s2_d;
  logic [2:0]  state_q, state_d;
  logic [5:0]  pre_cnt_q, pre_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] sh_q, sh_d;
  logic        is_wr_q, is_wr_d;
  logic [4:0]  regad_q, regad_d;
  logic [15:0] reg0_q, reg0_d;
  logic [15:0] scr_q [4];
  logic [15:0] scr_d [4];
  logic        out_q, out_d, oe_q, oe_d;
  logic        wr_strobe_q, wr_strobe_d, frame_err_q, frame_err_d;
  logic [4:0]  wr_addr_q, wr_addr_d;

  logic        rise_evt, fall_evt, bit_in;
  logic [4:0]  rd_addr;
  logic [15:0] rd_data, wdata;

  assign rise_evt = mdc_s2_q & ~mdc_dly_q;
  assign fall_evt = ~mdc_s2_q & mdc_dly_q;
  assign bit_in   = mdio_s2_q;
  assign rd_addr  = {sh_q[3:0], bit_in};
  assign wdata    = {sh_q[14:0], bit_in};

  always_comb begin
    rd_data = 16'h0000;
    case (rd_addr)
      5'd0:                   rd_data = reg0_q;
      5'd1:                   rd_data = 16'h7809 | {13'b0, link_up, 2'b00};
      5'd2:                   rd_data = ID1;
      5'd3:                   rd_data = ID2;
      5'd4, 5'd5, 5'd6, 5'd7: rd_data = scr_q[rd_addr[1:0]];
      default:                rd_data = 16'h0000;
    endcase
  end

  always_comb begin
    mdc_s1_d    = mdc;
    mdc_s2_d    = mdc_s1_q;
    mdc_dly_d   = mdc_s2_q;
    mdio_s1_d   = mdio_in;
    mdio_s2_d   = mdio_s1_q;
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    is_wr_d     = is_wr_q;
    regad_d     = regad_q;
    reg0_d      = reg0_q;
    for (int i = 0; i < 4; i++) scr_d[i] = scr_q[i];
    out_d       = out_q;
    oe_d        = oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: if (rise_evt) begin
        if (bit_in) begin
          if (pre_cnt_q != 6'd32) pre_cnt_d = pre_cnt_q + 6'd1;
        end else if (pre_cnt_q >= 6'(MIN_PREAMBLE)) begin
          state_d   = S_ST2;
          pre_cnt_d = 6'd0;
          bit_cnt_d = 5'd0;
        end else begin
          pre_cnt_d = 6'd0;
        end
      end
      S_ST2: if (rise_evt) begin
        bit_cnt_d = 5'd0;
        if (bit_in) state_d = S_OP;
        else begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end
      end
      S_OP: if (rise_evt) begin
        sh_d      = {sh_q[14:0], bit_in};
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd1) begin
          bit_cnt_d = 5'd0;
          case ({sh_q[0], bit_in})
            2'b10: begin is_wr_d = 1'b0; state_d = S_PHYAD; end
            2'b01: begin is_wr_d = 1'b1; state_d = S_PHYAD; end
            default: begin state_d = S_IDLE; frame_err_d = 1'b1; end
          endcase
        end
      end
      S_PHYAD: if (rise_evt) begin
        sh_d      = {sh_q[14:0], bit_in};
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd4) begin
          bit_cnt_d = 5'd0;
          state_d   = (rd_addr == PHY_ADDR) ? S_REGAD : S_IDLE;
        end
      end
      S_REGAD: if (rise_evt) begin
        sh_d      = {sh_q[14:0], bit_in};
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd4) begin
          bit_cnt_d = 5'd0;
          regad_d   = rd_addr;
          if (is_wr_q) state_d = S_WTA;
          else begin
            sh_d    = rd_data;
            state_d = S_RD;
          end
        end
      end
      S_WTA: if (rise_evt) begin
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd1) begin
          bit_cnt_d = 5'd0;
          state_d   = S_WDATA;
        end
      end
      S_WDATA: if (rise_evt) begin
        sh_d      = wdata;
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd15) begin
          bit_cnt_d = 5'd0;
          state_d   = S_IDLE;
          case (regad_q)
            5'd0: begin
              wr_strobe_d = 1'b1;
              wr_addr_d   = regad_q;
              // Bit 15 is a soft reset of every writable register, never stored.
              if (wdata[15]) begin
                reg0_d = REG0_RST;
                for (int i = 0; i < 4; i++) scr_d[i] = 16'h0000;
              end else begin
                reg0_d = {1'b0, wdata[14:0]};
              end
            end
            5'd4, 5'd5, 5'd6, 5'd7: begin
              wr_strobe_d              = 1'b1;
              wr_addr_d                = regad_q;
              scr_d[regad_q[1:0]]      = wdata;
            end
            default: ;
          endcase
        end
      end
      S_RD: if (fall_evt) begin
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd1) begin
          oe_d  = 1'b1;
          out_d = 1'b0;
        end else if (bit_cnt_q >= 5'd2 && bit_cnt_q <= 5'd17) begin
          out_d = sh_q[15];
          sh_d  = {sh_q[14:0], 1'b0};
        end else if (bit_cnt_q == 5'd18) begin
          oe_d      = 1'b0;
          out_d     = 1'b1;
          bit_cnt_d = 5'd0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      mdc_s1_q    <= 1'b0;
      mdc_s2_q    <= 1'b0;
      mdc_dly_q   <= 1'b0;
      mdio_s1_q   <= 1'b1;
      mdio_s2_q   <= 1'b1;
      state_q     <= S_IDLE;
      pre_cnt_q   <= 6'd0;
      bit_cnt_q   <= 5'd0;
      sh_q        <= 16'h0000;
      is_wr_q     <= 1'b0;
      regad_q     <= 5'd0;
      reg0_q      <= REG0_RST;
      for (int i = 0; i < 4; i++) scr_q[i] <= 16'h0000;
      out_q       <= 1'b1;
      oe_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 5'd0;
      frame_err_q <= 1'b0;
    end else begin
      mdc_s1_q    <= mdc_s1_d;
      mdc_s2_q    <= mdc_s2_d;
      mdc_dly_q   <= mdc_dly_d;
      mdio_s1_q   <= mdio_s1_d;
      mdio_s2_q   <= mdio_s2_d;
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      is_wr_q     <= is_wr_d;
      regad_q     <= regad_d;
      reg0_q      <= reg0_d;
      for (int i = 0; i < 4; i++) scr_q[i] <= scr_d[i];
      out_q       <= out_d;
      oe_q        <= oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign mdio_out  = out_q;
  assign mdio_oe   = oe_q;
  assign ctrl_reg  = reg0_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

endmodule
